// File: rtl/grey_div_ctrl_pkg.sv
// Shared state encoding, default ratio and next-grey helper for the
// programmable grey tick sequencer.
package grey_div_ctrl_pkg;

    localparam logic [5:0] DEF_DIV = 6'd12;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Reflected-code successor: decode to binary, add one, re-encode.
    function automatic logic [5:0] f_grey6(input logic [5:0] g);
        logic [5:0] b;
        b[5] = g[5];
        for (int i = 4; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        b = b + 6'd1;
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/grey_div_ctrl_grey_cnt6.sv
// Six-bit reflected-code tick counter; steps once per incr, clear has priority.
module grey_cnt6 (
    input  logic       clk,
    input  logic       rst,
    input  logic       incr,
    input  logic       clr,
    output logic [5:0] grey
);
    import grey_div_ctrl_pkg::*;

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            grey <= '0;
        end else if (incr) begin
            grey <= f_grey6(grey);
        end
    end

endmodule

// File: rtl/grey_div_ctrl.sv
// Programmable clock divider issuing grey-counter ticks; ratio updates only at
// period boundaries. Optional `wrap` pulse enabled by GREY_DIV_CTRL_WRAP_EN.
module grey_div_ctrl #(
    parameter int               DIV_W   = 6,
    parameter logic [DIV_W-1:0] DEF_DIV = grey_div_ctrl_pkg::DEF_DIV
) (
`ifdef USE_POWER_PINS
    inout  wire              vccd1,
    inout  wire              vssd1,
`endif
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    input  logic             grey_clr,
    output logic             incr,
    output logic             busy,
    output logic [5:0]       grey
`ifdef GREY_DIV_CTRL_WRAP_EN
    ,
    output logic             wrap
`endif
);
    import grey_div_ctrl_pkg::*;

    state_t           state, state_nx;
    logic [DIV_W-1:0] r_cnt, r_div, cnt_nx, div_nx;
    logic             terminal, accept, clr_eff;

    assign terminal  = (r_cnt == r_div);
    assign cfg_ready = (state == STOP) || terminal;
    assign accept    = cfg_valid && cfg_ready;
    assign clr_eff   = grey_clr && (state == STOP);

    // A run request always wins; otherwise a draining period ends in STOP at its tick.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_nx = state;
        cnt_nx   = r_cnt;
        div_nx   = accept ? cfg_div : r_div;
        case (state)
            STOP: begin
                cnt_nx = '0;
                if (run) state_nx = RUN;
            end
            RUN, HALT: begin
                cnt_nx = terminal ? '0 : r_cnt + 1'b1;
                if (run)           state_nx = RUN;
                else if (terminal) state_nx = STOP;
                else               state_nx = HALT;
            end
            default: begin
                state_nx = STOP;
                cnt_nx   = '0;
            end
        endcase
    end

    // incr and busy are looked ahead one edge so they line up with the cycle they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STOP;
            r_cnt <= '0;
            r_div <= DEF_DIV;
            incr  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            r_cnt <= cnt_nx;
            r_div <= div_nx;
            incr  <= (state_nx != STOP) && (cnt_nx == div_nx);
            busy  <= (state_nx != STOP);
        end
    end

    grey_cnt6 u_grey (
        .clk  (clk),
        .rst  (rst),
        .incr (incr),
        .clr  (clr_eff),
        .grey (grey)
    );

`ifdef GREY_DIV_CTRL_WRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= incr && !clr_eff && (grey == 6'b100000);
        end
    end
`endif

endmodule

// File: tb/tb_grey_div_ctrl.sv
// Self-checking bench for grey_div_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a cycle-level reference model.
module tb_grey_div_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [5:0] cfg_div = 6'd0;
    logic       grey_clr = 1'b0;
    logic       cfg_ready, incr, busy;
    logic [5:0] grey;
`ifdef GREY_DIV_CTRL_WRAP_EN
    logic       wrap;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    grey_div_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .grey_clr  (grey_clr),
        .incr      (incr),
        .busy      (busy),
        .grey      (grey)
`ifdef GREY_DIV_CTRL_WRAP_EN
        ,
        .wrap      (wrap)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] to_gray(input int n);
        logic [5:0] b;
        b = 6'(n);
        return b ^ (b >> 1);
    endfunction

    // Reference model: idle flag, position within the period, ratio, tick count.
    bit m_known = 1'b0;
    bit m_idle  = 1'b1;
    bit m_wrap  = 1'b0;
    int m_phase = 0;
    int m_div   = 12;
    int m_ticks = 0;

    always @(negedge clk) begin
        bit tick_now;
        bit acc;
        if (m_known) begin
            tick_now = !m_idle && (m_phase == m_div);
            check("m_incr",  int'(incr),      int'(tick_now));
            check("m_ready", int'(cfg_ready), int'(m_idle || m_phase == m_div));
            check("m_busy",  int'(busy),      int'(!m_idle));
            check("m_grey",  int'(grey),      int'(to_gray(m_ticks)));
`ifdef GREY_DIV_CTRL_WRAP_EN
            check("m_wrap",  int'(wrap),      int'(m_wrap));
`endif
        end
        if (rst) begin
            m_known = 1'b1;
            m_idle  = 1'b1;
            m_wrap  = 1'b0;
            m_phase = 0;
            m_div   = 12;
            m_ticks = 0;
        end else if (m_known) begin
            acc    = cfg_valid && (m_idle || m_phase == m_div);
            m_wrap = 1'b0;
            if (m_idle) begin
                if (grey_clr) m_ticks = 0;
                if (run) begin
                    m_idle  = 1'b0;
                    m_phase = 0;
                end
            end else if (m_phase == m_div) begin
                m_ticks = (m_ticks + 1) % 64;
                m_wrap  = (m_ticks == 0);
                m_phase = 0;
                if (!run) m_idle = 1'b1;
            end else begin
                m_phase++;
            end
            if (acc) m_div = int'(cfg_div);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Advances until an incr cycle; n is the distance from the starting cycle.
    task automatic wait_incr(input int budget, output int n);
        n = 0;
        do begin
            cyc();
            @(negedge clk);
            n++;
        end while (!incr && n < budget);
        check("incr_seen", int'(incr), 1);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        do begin
            cyc();
            @(negedge clk);
            k++;
        end while (busy && k < budget);
        check("idle_reached", int'(busy), 0);
    endtask

    logic [5:0] seq_tbl [5];
    int n, k, cnt, wraps;

    initial begin
        seq_tbl[0] = 6'b000000; seq_tbl[1] = 6'b000001; seq_tbl[2] = 6'b000011;
        seq_tbl[3] = 6'b000010; seq_tbl[4] = 6'b000110;

        cyc(); cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst_incr",  int'(incr), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_grey",  int'(grey), 0);
        check("rst_ready", int'(cfg_ready), 1);

        // Ratio 3 accepted in STOP together with run.
        cyc();
        cfg_valid = 1'b1; cfg_div = 6'd3; run = 1'b1;
        wait_incr(20, n);
        check("first_tick_lat", n, 4);
        check("grey_seq0", int'(grey), int'(seq_tbl[0]));
        for (int i = 1; i < 5; i++) begin
            wait_incr(20, n);
            check("tick_period4", n, 4);
            check("grey_seq", int'(grey), int'(seq_tbl[i]));
        end

        // Offer 5 mid-period: taken at the next boundary only.
        cyc();
        cfg_div = 6'd5;
        wait_incr(20, n);
        check("accept_at_term", n, 3);
        cyc();
        cfg_valid = 1'b0;
        wait_incr(20, n);
        check("div5_period", n, 5);
        cyc(); cyc();
        cfg_valid = 1'b1; cfg_div = 6'd1;
        k = 0;
        @(negedge clk);
        while (!cfg_ready && k < 20) begin
            k++;
            cyc();
            @(negedge clk);
        end
        check("ready_wait", k, 4);
        check("ready_on_tick", int'(incr), 1);
        wait_incr(20, n);
        check("div1_period_a", n, 2);
        wait_incr(20, n);
        check("div1_period_b", n, 2);

        // Ratio 7, drop run at r_cnt=2: one final tick then STOP.
        cyc();
        cfg_div = 6'd7;
        wait_incr(20, n);
        check("accept7", n, 1);
        cyc();
        cfg_valid = 1'b0;
        cyc(); cyc();
        run = 1'b0;
        wait_incr(20, n);
        check("drain_len", n, 5);
        check("drain_busy", int'(busy), 1);
        cyc();
        @(negedge clk);
        check("stopped_busy", int'(busy), 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            @(negedge clk);
            cnt += int'(incr);
        end
        check("no_tick_in_stop", cnt, 0);

        // Drop run at r_cnt=2, reassert at r_cnt=4: cadence unchanged.
        cyc();
        run = 1'b1;
        wait_incr(20, n);
        check("restart_lat", n, 8);
        cyc(); cyc(); cyc();
        run = 1'b0;
        cyc(); cyc();
        run = 1'b1;
        wait_incr(20, n);
        check("resume_tick", n, 3);
        check("resume_busy", int'(busy), 1);
        wait_incr(20, n);
        check("resume_period", n, 8);

        // Ratio 0 from a cleared counter: 64 ticks in 64 cycles, grey wraps.
        cyc();
        run = 1'b0;
        wait_idle(40);
        cyc();
        grey_clr = 1'b1;
        cyc();
        grey_clr = 1'b0; cfg_valid = 1'b1; cfg_div = 6'd0; run = 1'b1;
        @(negedge clk);
        check("clr_in_stop_a", int'(grey), 0);
        cyc();
        cfg_valid = 1'b0;
        cnt = 0;
        wraps = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            cnt += int'(incr);
`ifdef GREY_DIV_CTRL_WRAP_EN
            wraps += int'(wrap);
`endif
            cyc();
        end
        @(negedge clk);
        check("div0_tick_count", cnt, 64);
        check("div0_grey_wrap", int'(grey), 0);
`ifdef GREY_DIV_CTRL_WRAP_EN
        wraps += int'(wrap);
        check("wrap_once", wraps, 1);
`endif

        // grey_clr ignored while running; reset mid-period restores defaults.
        cyc();
        cfg_valid = 1'b1; cfg_div = 6'd3;
        cyc();
        cfg_valid = 1'b0; grey_clr = 1'b1;
        cyc();
        grey_clr = 1'b0;
        @(negedge clk);
        check("clr_ignored_run", int'(grey), 3);
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst2_incr",  int'(incr), 0);
        check("rst2_busy",  int'(busy), 0);
        check("rst2_grey",  int'(grey), 0);
        check("rst2_ready", int'(cfg_ready), 1);
        wait_incr(40, n);
        check("reset_div12", n, 13);
        cyc();
        run = 1'b0;
        wait_idle(40);
        check("grey_two_ticks", int'(grey), 3);
        cyc();
        grey_clr = 1'b1;
        cyc();
        grey_clr = 1'b0;
        @(negedge clk);
        check("clr_in_stop_b", int'(grey), 0);

        // Randomized traffic; the model process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst       = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) run = ~run;
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_div   = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                                    : 6'($urandom_range(0, 5));
            grey_clr  = ($urandom_range(0, 3) == 0);
        end
        cyc();
        rst = 1'b0; run = 1'b0; cfg_valid = 1'b0; grey_clr = 1'b0;
        repeat (4) cyc();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
